ecdsa_csr_slave: RTL and testbench
==================================

# ecdsa_csr_slave

AXI4-Lite responder for the ECDSA core's control/status register file. It terminates the `s_axi_csrs_*` port that the host (or the bench's AXI-Lite initiator) drives. It holds the COMMAND, RXADDR, TXADDR and scratch registers and presents them to the core. Reads at offset 0 return the core's live STATUS word, which the host polls for completion.

## Interface
- `NUM_REGS`, default 4: number of 32-bit word registers; valid word index range is 0..NUM_REGS-1.
- `ADDR_W`, default 12: AXI byte-address width.
- `clk`  in  1  single clock; all logic is rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `s_axi_csrs_awaddr`  in  ADDR_W  write address.
- `s_axi_csrs_awvalid` in 1 / `s_axi_csrs_awready` out 1: AW handshake.
- `s_axi_csrs_wdata`  in  32  write data.
- `s_axi_csrs_wstrb`  in  4  byte strobes.
- `s_axi_csrs_wvalid` in 1 / `s_axi_csrs_wready` out 1: W handshake.
- `s_axi_csrs_bresp`  out  2  write response.
- `s_axi_csrs_bvalid` out 1 / `s_axi_csrs_bready` in 1: B handshake.
- `s_axi_csrs_araddr`  in  ADDR_W  read address.
- `s_axi_csrs_arvalid` in 1 / `s_axi_csrs_arready` out 1: AR handshake.
- `s_axi_csrs_rdata`  out  32  read data.
- `s_axi_csrs_rresp`  out  2  read response.
- `s_axi_csrs_rvalid` out 1 / `s_axi_csrs_rready` in 1: R handshake.
- `status`  in  32  core status word; bit 0 = done.
- `command`  out  32  current COMMAND register value.
- `command_wr`  out  1  one-cycle pulse on every committed COMMAND write.
- `rxaddr`  out  32  RXADDR register.
- `txaddr`  out  32  TXADDR register.

## Operation
- Word index = `addr[ADDR_W-1:2]`. Bits [1:0] are ignored.
- Register map:
  - Index 0: write updates COMMAND; read returns `status`. COMMAND is not readable.
  - Index 1: RXADDR, read/write.
  - Index 2: TXADDR, read/write.
  - Index 3 up to NUM_REGS-1: scratch, read/write.
- Write channel has three states: IDLE, HOLD and RESP.
  - AW and W are captured independently into holding slots, in either order or in the same cycle.
  - Each ready is high only while its slot is empty and `bvalid` is low.
  - With both slots full, the next edge commits the write, sets `bvalid`, and clears both slots.
  - `bvalid` holds until `bready`; AW/W readies stay low meanwhile.
- Read channel has two states: IDLE and RESP.
  - `arready` is high only when `rvalid` is low.
  - On the edge after the AR handshake, `rdata`, `rresp` and `rvalid` are registered.
  - `rvalid` holds with `rdata` stable until `rready`.
- Read and write channels are fully independent.
- Out-of-range index (index ≥ NUM_REGS):
  - Write: discarded, `bresp` = 2'b10 (SLVERR).
  - Read: `rdata` = 0, `rresp` = 2'b10.
- In-range accesses return `resp` = 2'b00 (OKAY).

## Timing
- Reset (asynchronous, while `resetn` = 0):
  - All registers, `command`, `rxaddr`, `txaddr`, `rdata`, `bresp` and `rresp` are 0.
  - `bvalid`, `rvalid` and `command_wr` are 0.
  - `awready`, `wready` and `arready` are 0.
- Readies go high on the first rising edge after reset is released.
- Reset mid-transaction discards held AW/W and any pending B/R responses. No response is issued for them.
- Write latency: last of the AW/W handshakes at edge N → register, outputs, `bvalid` and `command_wr` all update at edge N+1.
- After a B handshake at edge M, `awready`/`wready` are high from edge M.
- Read latency: AR handshake at edge N → `rvalid` and `rdata` at edge N+1. `arready` is low from N until the R handshake edge.
- `status` is sampled at edge N+1 and is not re-sampled while `rvalid` is held.
- If a write commits at the same edge a read samples the same register, the read returns the pre-write value.
- `command_wr` is high for exactly one cycle per COMMAND write, including repeated writes of the same value. It does not pulse on an out-of-range write.

## Configuration
- `ECDSA_CSR_WSTRB_EN`:
  - Defined: byte lane k is written only if `wstrb[k]` = 1. `wstrb` = 0 still commits (no byte changes), returns OKAY and, at index 0, pulses `command_wr`.
  - Undefined: `wstrb` is ignored and every write updates all 32 bits.

## Test plan
- Write RXADDR (0x004) = 0x100, then TXADDR (0x008) = 0x080 → `rxaddr` = 0x100, `txaddr` = 0x080, both `bresp` = OKAY; readback returns 0x100 and 0x080.
- Write COMMAND (0x000) = 1 → `command` = 1, `command_wr` high for one cycle. Read 0x000 with `status` = 0 → 0; set `status` = 1 → next read returns 1.
- W presented 3 cycles before AW; then AW and W in the same cycle → each write commits exactly once, and `bvalid` rises one edge after the later handshake.
- Hold `bready` low 5 cycles after a write → `bvalid` and `bresp` stay stable, and `awready`/`wready` stay low for the whole wait.
- Write 0x010 = 0xDEADBEEF and read 0x010 (NUM_REGS = 4) → both return SLVERR, the read returns `rdata` = 0, and no register changes.
- With `ECDSA_CSR_WSTRB_EN`: scratch (0x00C) = 0x11223344, then write 0xAABBCCDD with `wstrb` = 4'b0001 → readback 0x112233DD. Without the macro the readback is 0xAABBCCDD.

Source files
------------

// File: rtl/ecdsa_csr_slave.sv
// ecdsa_csr_slave
// ---------------------------------------------------------------------------
// AXI4-Lite responder for the ECDSA core's control/status register file.
// It holds COMMAND, RXADDR, TXADDR and scratch words and presents them to
// the core. A read of word 0 returns the core's live STATUS word instead of
// COMMAND, so the host can poll for completion.
//
// Parameters:
//   NUM_REGS  number of 32-bit word registers (word indices 0..NUM_REGS-1,
//             must be at least 3)
//   ADDR_W    AXI byte-address width
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   s_axi_csrs_aw*/w*/b*     AXI4-Lite write address, data, response
//   s_axi_csrs_ar*/r*        AXI4-Lite read address, data
//   status                   core status word (bit 0 = done), read at word 0
//   command, command_wr      COMMAND register and its one-cycle write pulse
//   rxaddr, txaddr           RXADDR and TXADDR registers
//
// Build option:
//   ECDSA_CSR_WSTRB_EN  when defined, byte lanes are written only where
//                       wstrb is set; otherwise every write replaces all
//                       32 bits.
// ---------------------------------------------------------------------------
module ecdsa_csr_slave #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] s_axi_csrs_awaddr,
    input  logic              s_axi_csrs_awvalid,
    output logic              s_axi_csrs_awready,
    input  logic [31:0]       s_axi_csrs_wdata,
    input  logic [3:0]        s_axi_csrs_wstrb,
    input  logic              s_axi_csrs_wvalid,
    output logic              s_axi_csrs_wready,
    output logic [1:0]        s_axi_csrs_bresp,
    output logic              s_axi_csrs_bvalid,
    input  logic              s_axi_csrs_bready,
    input  logic [ADDR_W-1:0] s_axi_csrs_araddr,
    input  logic              s_axi_csrs_arvalid,
    output logic              s_axi_csrs_arready,
    output logic [31:0]       s_axi_csrs_rdata,
    output logic [1:0]        s_axi_csrs_rresp,
    output logic              s_axi_csrs_rvalid,
    input  logic              s_axi_csrs_rready,
    input  logic [31:0]       status,
    output logic [31:0]       command,
    output logic              command_wr,
    output logic [31:0]       rxaddr,
    output logic [31:0]       txaddr
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HOLD, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_RESP} rstate_t;

    wstate_t          wstate;
    rstate_t          rstate;
    logic [31:0]      regs [NUM_REGS];

    logic             aw_full;
    logic             w_full;
    logic             ar_full;
    logic [IDX_W-1:0] aw_idx;
    logic [IDX_W-1:0] ar_idx;
    logic [31:0]      w_data;

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             aw_in_range;
    logic             ar_in_range;
    logic [31:0]      rd_val;
    logic             unused_bits;

`ifdef ECDSA_CSR_WSTRB_EN
    logic [3:0]       w_strb;

    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = strb[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
        end
        return res;
    endfunction

    assign unused_bits = ^{s_axi_csrs_awaddr[1:0], s_axi_csrs_araddr[1:0]};
`else
    assign unused_bits = ^{s_axi_csrs_awaddr[1:0], s_axi_csrs_araddr[1:0],
                           s_axi_csrs_wstrb};
`endif

    assign aw_hs       = s_axi_csrs_awvalid & s_axi_csrs_awready;
    assign w_hs        = s_axi_csrs_wvalid  & s_axi_csrs_wready;
    assign ar_hs       = s_axi_csrs_arvalid & s_axi_csrs_arready;
    assign aw_in_range = 32'(aw_idx) < NUM_REGS;
    assign ar_in_range = 32'(ar_idx) < NUM_REGS;

    assign command = regs[0];
    assign rxaddr  = regs[1];
    assign txaddr  = regs[2];

    // Word 0 reads back STATUS, never COMMAND; out-of-range indices read 0.
    always_comb begin
        rd_val = '0;
        if (ar_idx == '0) begin
            rd_val = status;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (32'(ar_idx) == i) rd_val = regs[i];
            end
        end
    end

    // Write channel: AW and W fill independent slots; once both are full the
    // following edge commits and raises bvalid. Readies are registered and
    // stay low while a slot is occupied or a response is outstanding.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate             <= W_IDLE;
            aw_full            <= 1'b0;
            w_full             <= 1'b0;
            aw_idx             <= '0;
            w_data             <= '0;
`ifdef ECDSA_CSR_WSTRB_EN
            w_strb             <= '0;
`endif
            s_axi_csrs_awready <= 1'b0;
            s_axi_csrs_wready  <= 1'b0;
            s_axi_csrs_bvalid  <= 1'b0;
            s_axi_csrs_bresp   <= OKAY;
            command_wr         <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            command_wr <= 1'b0;
            case (wstate)
                W_IDLE, W_HOLD: begin
                    if (aw_full && w_full) begin
                        if (aw_in_range) begin
                            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                                if (32'(aw_idx) == i) begin
`ifdef ECDSA_CSR_WSTRB_EN
                                    regs[i] <= merge_strb(regs[i], w_data, w_strb);
`else
                                    regs[i] <= w_data;
`endif
                                end
                            end
                            // Pulses even when the value is unchanged so the
                            // core can re-issue the same command.
                            if (aw_idx == '0) command_wr <= 1'b1;
                        end
                        s_axi_csrs_bresp  <= aw_in_range ? OKAY : SLVERR;
                        s_axi_csrs_bvalid <= 1'b1;
                        aw_full           <= 1'b0;
                        w_full            <= 1'b0;
                        wstate            <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_full <= 1'b1;
                            aw_idx  <= s_axi_csrs_awaddr[ADDR_W-1:2];
                        end
                        if (w_hs) begin
                            w_full <= 1'b1;
                            w_data <= s_axi_csrs_wdata;
`ifdef ECDSA_CSR_WSTRB_EN
                            w_strb <= s_axi_csrs_wstrb;
`endif
                        end
                        s_axi_csrs_awready <= ~(aw_full | aw_hs);
                        s_axi_csrs_wready  <= ~(w_full | w_hs);
                        wstate <= (aw_full | aw_hs | w_full | w_hs) ? W_HOLD : W_IDLE;
                    end
                end
                W_RESP: begin
                    if (s_axi_csrs_bready) begin
                        s_axi_csrs_bvalid  <= 1'b0;
                        s_axi_csrs_awready <= 1'b1;
                        s_axi_csrs_wready  <= 1'b1;
                        wstate             <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel: the address is latched at the AR handshake and the data
    // (including STATUS) is sampled on the next edge, then held until rready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate             <= R_IDLE;
            ar_full            <= 1'b0;
            ar_idx             <= '0;
            s_axi_csrs_arready <= 1'b0;
            s_axi_csrs_rvalid  <= 1'b0;
            s_axi_csrs_rdata   <= '0;
            s_axi_csrs_rresp   <= OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_full) begin
                        s_axi_csrs_rdata  <= rd_val;
                        s_axi_csrs_rresp  <= ar_in_range ? OKAY : SLVERR;
                        s_axi_csrs_rvalid <= 1'b1;
                        ar_full           <= 1'b0;
                        rstate            <= R_RESP;
                    end else begin
                        if (ar_hs) begin
                            ar_full <= 1'b1;
                            ar_idx  <= s_axi_csrs_araddr[ADDR_W-1:2];
                        end
                        s_axi_csrs_arready <= ~ar_hs;
                    end
                end
                R_RESP: begin
                    if (s_axi_csrs_rready) begin
                        s_axi_csrs_rvalid  <= 1'b0;
                        s_axi_csrs_arready <= 1'b1;
                        rstate             <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecdsa_csr_slave.sv
// Directed bench for ecdsa_csr_slave with a response scoreboard: expected
// B and R responses are queued when a transaction is driven and compared
// when the DUT presents the response.
module tb_ecdsa_csr_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, status, command, rxaddr, txaddr;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        command_wr;

    int total = 0;
    int bad   = 0;
    int cwr_cnt = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    ecdsa_csr_slave #(.NUM_REGS(4), .ADDR_W(12)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .s_axi_csrs_awaddr  (awaddr),
        .s_axi_csrs_awvalid (awvalid),
        .s_axi_csrs_awready (awready),
        .s_axi_csrs_wdata   (wdata),
        .s_axi_csrs_wstrb   (wstrb),
        .s_axi_csrs_wvalid  (wvalid),
        .s_axi_csrs_wready  (wready),
        .s_axi_csrs_bresp   (bresp),
        .s_axi_csrs_bvalid  (bvalid),
        .s_axi_csrs_bready  (bready),
        .s_axi_csrs_araddr  (araddr),
        .s_axi_csrs_arvalid (arvalid),
        .s_axi_csrs_arready (arready),
        .s_axi_csrs_rdata   (rdata),
        .s_axi_csrs_rresp   (rresp),
        .s_axi_csrs_rvalid  (rvalid),
        .s_axi_csrs_rready  (rready),
        .status             (status),
        .command            (command),
        .command_wr         (command_wr),
        .rxaddr             (rxaddr),
        .txaddr             (txaddr)
    );

    always #5 clk = ~clk;

    // Counts rising edges on which command_wr is seen high.
    always @(posedge clk) if (resetn === 1'b1 && command_wr === 1'b1) cwr_cnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Drives AW and W together; checks bvalid rises exactly one edge after
    // the later handshake.
    task automatic write_req(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er);
        bit aw_done, w_done, hs_aw, hs_w;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        bq.push_back(er);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            step();
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin wvalid  = 1'b0; w_done  = 1; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_handshake", 32'(aw_done && w_done), 32'd1);
        check("b_before_commit", 32'(bvalid), 32'd0);
        step();
        check("b_latency", 32'(bvalid), 32'd1);
    endtask

    task automatic wait_b();
        int n;
        logic [1:0] er;
        n = 0;
        bready = 1'b1;
        while (bvalid !== 1'b1 && n < 50) begin step(); n++; end
        check("b_timeout", 32'(n < 50), 32'd1);
        er = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
        check("bresp", 32'(bresp), 32'(er));
        step();
        check("b_done_ready", {29'b0, bvalid, awready, wready}, 32'h3);
    endtask

    task automatic read_req(input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er);
        bit done, hs;
        int n;
        done = 0; n = 0;
        rq.push_back({er, ed});
        araddr = a; arvalid = 1'b1;
        while (!done && n < 50) begin
            hs = arvalid && arready;
            step();
            if (hs) begin arvalid = 1'b0; done = 1; end
            n++;
        end
        arvalid = 1'b0;
        check("rd_handshake", 32'(done), 32'd1);
        check("r_before_sample", {30'b0, rvalid, arready}, 32'h0);
        step();
        check("r_latency", 32'(rvalid), 32'd1);
    endtask

    task automatic wait_r();
        int n;
        logic [33:0] e;
        n = 0;
        rready = 1'b1;
        while (rvalid !== 1'b1 && n < 50) begin step(); n++; end
        check("r_timeout", 32'(n < 50), 32'd1);
        e = (rq.size() > 0) ? rq.pop_front() : 34'hx;
        check("rdata", rdata, e[31:0]);
        check("rresp", 32'(rresp), 32'(e[33:32]));
        step();
        check("r_done_ready", {30'b0, rvalid, arready}, 32'h1);
    endtask

    initial begin
        int c0;
        logic [31:0] exp_cmd, exp_scr;

        resetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1; status = '0;

        // Reset values
        step();
        check("rst_readies", {29'b0, awready, wready, arready}, 32'h0);
        check("rst_valids", {29'b0, bvalid, rvalid, command_wr}, 32'h0);
        check("rst_command", command, 32'h0);
        check("rst_rxaddr", rxaddr, 32'h0);
        check("rst_txaddr", txaddr, 32'h0);
        check("rst_rdata_resp", {rdata[27:0], bresp, rresp}, 32'h0);
        resetn = 1'b1;
        step();
        check("ready_after_rst", {29'b0, awready, wready, arready}, 32'h7);

        // RXADDR / TXADDR
        write_req(12'h004, 32'h100, 4'hF, 2'b00); wait_b();
        write_req(12'h008, 32'h080, 4'hF, 2'b00); wait_b();
        check("rxaddr_out", rxaddr, 32'h100);
        check("txaddr_out", txaddr, 32'h080);
        read_req(12'h004, 32'h100, 2'b00); wait_r();
        read_req(12'h008, 32'h080, 2'b00); wait_r();

        // COMMAND writes, including a repeat of the same value
        c0 = cwr_cnt;
        write_req(12'h000, 32'h1, 4'hF, 2'b00); wait_b();
        check("command_out", command, 32'h1);
        check("command_wr_once", 32'(cwr_cnt - c0), 32'd1);
        write_req(12'h000, 32'h1, 4'hF, 2'b00); wait_b();
        check("command_wr_repeat", 32'(cwr_cnt - c0), 32'd2);

        // STATUS readback at word 0
        status = 32'h0;
        read_req(12'h000, 32'h0, 2'b00); wait_r();
        status = 32'h1;
        read_req(12'h000, 32'h1, 2'b00); wait_r();

        // W three cycles ahead of AW, to COMMAND
        wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
        bq.push_back(2'b00);
        check("w_first_ready", 32'(wready), 32'd1);
        step(); wvalid = 1'b0;
        check("w_slot_full", 32'(wready), 32'd0);
        step(); step();
        check("w_wait_no_b", {30'b0, bvalid, wready}, 32'h0);
        awaddr = 12'h000; awvalid = 1'b1;
        check("late_aw_ready", 32'(awready), 32'd1);
        step(); awvalid = 1'b0;
        check("late_aw_no_b", 32'(bvalid), 32'd0);
        step();
        check("late_aw_b", 32'(bvalid), 32'd1);
        wait_b();
        check("late_aw_command", command, 32'h2);
        check("late_aw_wr_once", 32'(cwr_cnt - c0), 32'd3);
        exp_cmd = 32'h2;

        // bready held low for 5 cycles on a scratch write
        bready = 1'b0;
        write_req(12'h00C, 32'h11223344, 4'hF, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step();
            check("b_hold", {27'b0, bvalid, bresp, awready, wready}, 32'h10);
        end
        wait_b();
        read_req(12'h00C, 32'h11223344, 2'b00); wait_r();

        // Partial strobe on scratch
`ifdef ECDSA_CSR_WSTRB_EN
        exp_scr = 32'h112233DD;
`else
        exp_scr = 32'hAABBCCDD;
`endif
        write_req(12'h00C, 32'hAABBCCDD, 4'b0001, 2'b00); wait_b();
        read_req(12'h00C, exp_scr, 2'b00); wait_r();

        // Zero strobe to COMMAND still commits and pulses command_wr
        c0 = cwr_cnt;
`ifdef ECDSA_CSR_WSTRB_EN
        exp_cmd = exp_cmd;
`else
        exp_cmd = 32'h7;
`endif
        write_req(12'h000, 32'h7, 4'b0000, 2'b00); wait_b();
        check("zero_strb_command", command, exp_cmd);
        check("zero_strb_wr", 32'(cwr_cnt - c0), 32'd1);

        // Out-of-range write and read
        c0 = cwr_cnt;
        write_req(12'h010, 32'hDEADBEEF, 4'hF, 2'b10); wait_b();
        check("oor_no_wr_pulse", 32'(cwr_cnt - c0), 32'd0);
        check("oor_command", command, exp_cmd);
        check("oor_rxaddr", rxaddr, 32'h100);
        check("oor_txaddr", txaddr, 32'h080);
        read_req(12'h010, 32'h0, 2'b10); wait_r();
        read_req(12'hFFC, 32'h0, 2'b10); wait_r();
        read_req(12'h00C, exp_scr, 2'b00); wait_r();

        // rdata held stable while rready is low, status not re-sampled
        status = 32'h1;
        rready = 1'b0;
        read_req(12'h000, 32'h1, 2'b00);
        status = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("r_hold", {rdata[29:0], rvalid, arready}, {30'h1, 2'b10});
        end
        wait_r();

        // Reset with AW held: the slot is discarded
        awaddr = 12'h008; awvalid = 1'b1;
        step(); awvalid = 1'b0;
        resetn = 1'b0;
        #1;
        check("mid_rst_outputs", {29'b0, awready, bvalid, rvalid}, 32'h0);
        check("mid_rst_txaddr", txaddr, 32'h0);
        step();
        resetn = 1'b1;
        step();
        check("mid_rst_ready", {29'b0, awready, wready, arready}, 32'h7);
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        step(); wvalid = 1'b0;
        step(); step(); step();
        check("mid_rst_no_b", {30'b0, bvalid, wready}, 32'h0);
        bq.push_back(2'b00);
        awaddr = 12'h004; awvalid = 1'b1;
        step(); awvalid = 1'b0;
        step();
        check("post_rst_b", 32'(bvalid), 32'd1);
        wait_b();
        check("post_rst_rxaddr", rxaddr, 32'h77);
        check("post_rst_txaddr", txaddr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
